// File: rtl/gemm_tile_scheduler.sv
// Layer-level tile scheduler for the img2col GEMM datapath.
// Latches a layer descriptor, drives the parameter-preparation stage and walks the
// output tile grid (kernel blocks outer, row-blocks inner) under an in-flight limit.
module gemm_tile_scheduler #(
  parameter int TENSOR_W     = 8,
  parameter int KERNEL_W     = 4,
  parameter int CHAN_W       = 8,
  parameter int STRIDE_W     = 4,
  parameter int KNUMS_W      = 8,
  parameter int ROWB_W       = 16,
  parameter int COLB_W       = 8,
  parameter int MAX_OUT      = 4,
  parameter int PREP_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [TENSOR_W-1:0] cfg_tensor_size,
  input  logic [KERNEL_W-1:0] cfg_kernel_size,
  input  logic [CHAN_W-1:0]   cfg_channels,
  input  logic [STRIDE_W-1:0] cfg_stride,
  input  logic [KNUMS_W-1:0]  cfg_kernel_nums,
  output logic                prep_start,
  output logic [TENSOR_W-1:0] prep_tensor_size,
  output logic [KERNEL_W-1:0] prep_kernel_size,
  output logic [CHAN_W-1:0]   prep_channels,
  output logic [STRIDE_W-1:0] prep_stride,
  output logic [KNUMS_W-1:0]  prep_kernel_nums,
  input  logic                prep_enable,
  input  logic [ROWB_W-1:0]   prep_row_blocks,
  input  logic [COLB_W-1:0]   prep_col_blocks,
  output logic                tile_valid,
  input  logic                tile_ready,
  output logic [ROWB_W-1:0]   tile_row,
  output logic [COLB_W-1:0]   tile_col,
  output logic                tile_last,
  input  logic                tile_done,
  output logic                busy,
  output logic                layer_done,
  output logic                err
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ISSUE, S_DRAIN, S_DONE} state_e;

  localparam int                WAIT_W    = $clog2(PREP_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(PREP_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [3:0]        MAX_OUT_C = 4'(MAX_OUT);
  localparam logic [3:0]        OUT_ONE   = 4'd1;
  localparam logic [ROWB_W-1:0] ROW_ONE   = ROWB_W'(1);
  localparam logic [COLB_W-1:0] COL_ONE   = COLB_W'(1);

  state_e              state_q, state_d;
  logic [TENSOR_W-1:0] tensor_q, tensor_d;
  logic [KERNEL_W-1:0] kernel_q, kernel_d;
  logic [CHAN_W-1:0]   chan_q, chan_d;
  logic [STRIDE_W-1:0] stride_q, stride_d;
  logic [KNUMS_W-1:0]  knums_q, knums_d;
  logic [ROWB_W-1:0]   row_blocks_q, row_blocks_d, row_q, row_d;
  logic [COLB_W-1:0]   col_blocks_q, col_blocks_d, col_q, col_d;
  logic [3:0]          outstanding_q, outstanding_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic                prep_start_q, prep_start_d;
  logic                tile_valid_q, tile_valid_d;
  logic                tile_last_q, tile_last_d;
  logic                busy_q, busy_d;
  logic                layer_done_q, layer_done_d;
  logic                err_q, err_d;
  logic                hs, done_ok, done_spurious;

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d       = state_q;
    tensor_d      = tensor_q;
    kernel_d      = kernel_q;
    chan_d        = chan_q;
    stride_d      = stride_q;
    knums_d       = knums_q;
    row_blocks_d  = row_blocks_q;
    col_blocks_d  = col_blocks_q;
    row_d         = row_q;
    col_d         = col_q;
    wait_cnt_d    = wait_cnt_q;
    err_d         = err_q;

    hs            = tile_valid_q && tile_ready;
    done_ok       = tile_done && (outstanding_q != '0);
    done_spurious = tile_done && (outstanding_q == '0);
    outstanding_d = outstanding_q;
    if (hs)      outstanding_d = outstanding_d + OUT_ONE;
    if (done_ok) outstanding_d = outstanding_d - OUT_ONE;
    if (done_spurious) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          tensor_d   = cfg_tensor_size;
          kernel_d   = cfg_kernel_size;
          chan_d     = cfg_channels;
          stride_d   = cfg_stride;
          knums_d    = cfg_kernel_nums;
          err_d      = done_spurious;
          wait_cnt_d = '0;
          state_d    = S_PREP;
        end
      end
      S_PREP: begin
        if (prep_enable) begin
          row_blocks_d = prep_row_blocks;
          col_blocks_d = prep_col_blocks;
          row_d        = '0;
          col_d        = '0;
          state_d      = (prep_row_blocks == '0 || prep_col_blocks == '0) ? S_DONE : S_ISSUE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end
      S_ISSUE: begin
        if (hs) begin
          if (tile_last_q) begin
            state_d = S_DRAIN;
          end else if (row_q == row_blocks_q - ROW_ONE) begin
            row_d = '0;
            col_d = col_q + COL_ONE;
          end else begin
            row_d = row_q + ROW_ONE;
          end
        end
      end
      S_DRAIN: begin
        if (outstanding_d == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are derived from the next state so they appear registered with it;
    // tile_last uses the freshly captured counts so it is right on the first tile.
    cfg_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    prep_start_d = state_d inside {S_PREP, S_ISSUE, S_DRAIN};
    layer_done_d = (state_d == S_DONE);
    tile_valid_d = (state_d == S_ISSUE) && (outstanding_d < MAX_OUT_C);
    tile_last_d  = (state_d == S_ISSUE) && (row_d == row_blocks_d - ROW_ONE) &&
                   (col_d == col_blocks_d - COL_ONE);
  end

  // State, counters, latched descriptor and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      tensor_q      <= '0;
      kernel_q      <= '0;
      chan_q        <= '0;
      stride_q      <= '0;
      knums_q       <= '0;
      row_blocks_q  <= '0;
      col_blocks_q  <= '0;
      row_q         <= '0;
      col_q         <= '0;
      outstanding_q <= '0;
      wait_cnt_q    <= '0;
      cfg_ready_q   <= 1'b1;
      prep_start_q  <= 1'b0;
      tile_valid_q  <= 1'b0;
      tile_last_q   <= 1'b0;
      busy_q        <= 1'b0;
      layer_done_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      tensor_q      <= tensor_d;
      kernel_q      <= kernel_d;
      chan_q        <= chan_d;
      stride_q      <= stride_d;
      knums_q       <= knums_d;
      row_blocks_q  <= row_blocks_d;
      col_blocks_q  <= col_blocks_d;
      row_q         <= row_d;
      col_q         <= col_d;
      outstanding_q <= outstanding_d;
      wait_cnt_q    <= wait_cnt_d;
      cfg_ready_q   <= cfg_ready_d;
      prep_start_q  <= prep_start_d;
      tile_valid_q  <= tile_valid_d;
      tile_last_q   <= tile_last_d;
      busy_q        <= busy_d;
      layer_done_q  <= layer_done_d;
      err_q         <= err_d;
    end
  end

  assign cfg_ready        = cfg_ready_q;
  assign prep_start       = prep_start_q;
  assign prep_tensor_size = tensor_q;
  assign prep_kernel_size = kernel_q;
  assign prep_channels    = chan_q;
  assign prep_stride      = stride_q;
  assign prep_kernel_nums = knums_q;
  assign tile_valid       = tile_valid_q;
  assign tile_row         = row_q;
  assign tile_col         = col_q;
  assign tile_last        = tile_last_q;
  assign busy             = busy_q;
  assign layer_done       = layer_done_q;
  assign err              = err_q;

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Randomized self-checking bench for gemm_tile_scheduler. The reference model tracks
// only tile index (row-major within each kernel block) and tiles in flight.
module tb_gemm_tile_scheduler;
  localparam int MAX_OUT      = 4;
  localparam int PREP_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_ready;
  logic [7:0]  cfg_tensor_size, cfg_channels, cfg_kernel_nums;
  logic [3:0]  cfg_kernel_size, cfg_stride;
  logic        prep_start;
  logic [7:0]  prep_tensor_size, prep_channels, prep_kernel_nums;
  logic [3:0]  prep_kernel_size, prep_stride;
  logic        prep_enable;
  logic [15:0] prep_row_blocks;
  logic [7:0]  prep_col_blocks;
  logic        tile_valid, tile_ready, tile_last, tile_done;
  logic [15:0] tile_row;
  logic [7:0]  tile_col;
  logic        busy, layer_done, err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gemm_tile_scheduler #(.MAX_OUT(MAX_OUT), .PREP_TIMEOUT(PREP_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_tensor_size(cfg_tensor_size), .cfg_kernel_size(cfg_kernel_size),
    .cfg_channels(cfg_channels), .cfg_stride(cfg_stride), .cfg_kernel_nums(cfg_kernel_nums),
    .prep_start(prep_start),
    .prep_tensor_size(prep_tensor_size), .prep_kernel_size(prep_kernel_size),
    .prep_channels(prep_channels), .prep_stride(prep_stride), .prep_kernel_nums(prep_kernel_nums),
    .prep_enable(prep_enable), .prep_row_blocks(prep_row_blocks), .prep_col_blocks(prep_col_blocks),
    .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_row(tile_row), .tile_col(tile_col),
    .tile_last(tile_last), .tile_done(tile_done),
    .busy(busy), .layer_done(layer_done), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(output logic [31:0] fields);
    check("cfg_ready_idle", 32'(cfg_ready), 1);
    cfg_tensor_size = 8'($urandom);
    cfg_kernel_size = 4'($urandom);
    cfg_channels    = 8'($urandom);
    cfg_stride      = 4'($urandom);
    cfg_kernel_nums = 8'($urandom);
    fields = {cfg_tensor_size, cfg_kernel_size, cfg_channels, cfg_stride, cfg_kernel_nums};
    cfg_valid = 1'b1;
    step();
    cfg_valid       = 1'b0;
    cfg_tensor_size = 8'($urandom);
    cfg_channels    = 8'($urandom);
  endtask

  task automatic run_layer(input int rb, input int cb, input int prep_lat, input int ready_pct,
                           input int done_pct, input int done_hold, input int stall_idx);
    logic [31:0] fields;
    int total, idx, pending, stall, cyc;
    bit exp_ld, ld_seen, hs;
    total = rb * cb;
    send_cfg(fields);
    check("accept_busy", 32'(busy), 1);
    check("accept_prep_start", 32'(prep_start), 1);
    check("accept_cfg_ready", 32'(cfg_ready), 0);
    check("accept_err", 32'(err), 0);
    check("prep_fields", {prep_tensor_size, prep_kernel_size, prep_channels, prep_stride,
                          prep_kernel_nums}, fields);
    for (int i = 0; i < prep_lat; i++) begin
      step();
      check("prep_wait_start", 32'(prep_start), 1);
      check("prep_wait_valid", 32'(tile_valid), 0);
    end
    prep_enable     = 1'b1;
    prep_row_blocks = 16'(rb);
    prep_col_blocks = 8'(cb);
    step();
    prep_enable     = 1'b0;
    prep_row_blocks = 16'($urandom);
    prep_col_blocks = 8'($urandom);

    idx = 0; pending = 0; stall = 0; cyc = 0; ld_seen = 1'b0;
    while (!ld_seen && cyc < 2000) begin
      exp_ld = (idx == total) && (pending == 0);
      check("layer_done", 32'(layer_done), 32'(exp_ld));
      check("prep_start", 32'(prep_start), 32'(!exp_ld));
      check("err_quiet", 32'(err), 0);
      check("tile_valid", 32'(tile_valid), 32'((idx < total) && (pending < MAX_OUT)));
      if (tile_valid && idx < total) begin
        check("tile_row", 32'(tile_row), idx % rb);
        check("tile_col", 32'(tile_col), idx / rb);
        check("tile_last", 32'(tile_last), 32'(idx == total - 1));
      end
      ld_seen = layer_done || exp_ld;
      if (!ld_seen) begin
        if (tile_valid && idx == stall_idx && stall < 5) begin
          tile_ready = 1'b0;
          stall++;
        end else begin
          tile_ready = ($urandom_range(99) < ready_pct);
        end
        tile_done = (pending > 0) && (cyc >= done_hold) && ($urandom_range(99) < done_pct);
        hs = tile_valid && tile_ready;
        if (hs) begin
          idx++;
          pending++;
        end
        if (tile_done) pending--;
        step();
        cyc++;
      end
    end
    tile_ready = 1'b0;
    tile_done  = 1'b0;
    check("layer_end_reached", 32'(ld_seen), 1);
    check("done_tile_valid", 32'(tile_valid), 0);
    check("done_cfg_ready", 32'(cfg_ready), 0);
    step();
    check("idle_layer_done", 32'(layer_done), 0);
    check("idle_cfg_ready", 32'(cfg_ready), 1);
    check("idle_busy", 32'(busy), 0);
    check("idle_prep_start", 32'(prep_start), 0);
  endtask

  task automatic run_timeout();
    logic [31:0] fields;
    send_cfg(fields);
    for (int i = 1; i < PREP_TIMEOUT; i++) begin
      step();
      check("to_wait_layer_done", 32'(layer_done), 0);
      check("to_wait_err", 32'(err), 0);
      check("to_wait_valid", 32'(tile_valid), 0);
    end
    step();
    check("to_err", 32'(err), 1);
    check("to_layer_done", 32'(layer_done), 1);
    check("to_prep_start", 32'(prep_start), 0);
    check("to_valid", 32'(tile_valid), 0);
    step();
    check("to_err_sticky", 32'(err), 1);
    check("to_cfg_ready", 32'(cfg_ready), 1);
    check("to_layer_done_pulse", 32'(layer_done), 0);
  endtask

  initial begin
    logic [31:0] fields;
    rst = 1'b1; cfg_valid = 1'b0; prep_enable = 1'b0; tile_ready = 1'b0; tile_done = 1'b0;
    cfg_tensor_size = '0; cfg_kernel_size = '0; cfg_channels = '0; cfg_stride = '0;
    cfg_kernel_nums = '0; prep_row_blocks = '0; prep_col_blocks = '0;
    step();
    rst = 1'b0;
    check("rst_cfg_ready", 32'(cfg_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_prep_start", 32'(prep_start), 0);
    check("rst_tile_valid", 32'(tile_valid), 0);
    check("rst_layer_done", 32'(layer_done), 0);
    check("rst_err", 32'(err), 0);

    // Reset in the middle of issuing with three tiles in flight.
    send_cfg(fields);
    prep_enable = 1'b1; prep_row_blocks = 16'd8; prep_col_blocks = 8'd1;
    step();
    prep_enable = 1'b0; tile_ready = 1'b1;
    step(); step(); step();
    check("pre_rst_valid", 32'(tile_valid), 1);
    check("pre_rst_row", 32'(tile_row), 3);
    tile_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", 32'(tile_valid), 0);
    check("mid_rst_prep_start", 32'(prep_start), 0);
    check("mid_rst_cfg_ready", 32'(cfg_ready), 1);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_fields", {prep_tensor_size, prep_kernel_size, prep_channels, prep_stride,
                             prep_kernel_nums}, 0);
    // A completion now is spurious only if the in-flight count was cleared.
    tile_done = 1'b1;
    step();
    tile_done = 1'b0;
    check("spurious_err", 32'(err), 1);
    check("spurious_busy", 32'(busy), 0);
    check("spurious_cfg_ready", 32'(cfg_ready), 1);
    step();
    check("spurious_err_sticky", 32'(err), 1);

    run_layer(2, 2, 5, 100, 100, 3, -1);   // ordered 2x2 grid
    run_layer(8, 1, 2, 100, 100, 10, -1);  // in-flight limit with completions withheld
    run_layer(4, 2, 1, 100, 50, 0, 2);     // back-pressure on tile (2,0)
    run_timeout();
    run_layer(3, 0, 0, 100, 100, 0, -1);   // zero kernel blocks, also clears err
    run_layer(0, 3, 4, 100, 100, 0, -1);   // zero row blocks
    run_layer(1, 1, 0, 100, 100, 0, -1);   // single tile
    for (int i = 0; i < 25; i++) begin
      run_layer($urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 10),
                $urandom_range(30, 100), $urandom_range(20, 100), $urandom_range(0, 6),
                $urandom_range(0, 8));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gemm_tile_scheduler.md
Name: gemm_tile_scheduler

Overview:
- Layer-level controller for the img2col GEMM datapath.
- Accepts one layer descriptor at a time and latches it. Drives the parameter-preparation stage (start/enable protocol) and waits for its derived block counts.
- Walks the output tile grid (kernel blocks outer, tensor row-blocks inner) and issues tile requests to the GEMM datapath under an outstanding-request limit.
- Pulses layer_done once every tile has completed.

Parameters:
- TENSOR_W, 8, width of tensor_size
- KERNEL_W, 4, width of kernel_size
- CHAN_W, 8, width of channels
- STRIDE_W, 4, width of stride
- KNUMS_W, 8, width of kernel_nums
- ROWB_W, 16, width of row-block count/index
- COLB_W, 8, width of column-block count/index
- MAX_OUT, 4, maximum tiles in flight (1..15)
- PREP_TIMEOUT, 64, cycles allowed for prep_enable to rise

Ports:
- clk  in  1  clock
- rst  in  1  reset: one clock; reset is synchronous and active-high
- cfg_valid  in  1  layer descriptor valid
- cfg_ready  out  1  scheduler can accept a descriptor
- cfg_tensor_size  in  TENSOR_W  input tensor edge
- cfg_kernel_size  in  KERNEL_W  kernel edge
- cfg_channels  in  CHAN_W  channel count
- cfg_stride  in  STRIDE_W  stride
- cfg_kernel_nums  in  KNUMS_W  kernel count
- prep_start  out  1  level start to the preparation stage
- prep_tensor_size / prep_kernel_size / prep_channels / prep_stride / prep_kernel_nums  out  as cfg  latched descriptor fields
- prep_enable  in  1  preparation results valid (level)
- prep_row_blocks  in  ROWB_W  number of tensor row-blocks
- prep_col_blocks  in  COLB_W  number of kernel blocks
- tile_valid  out  1  tile request valid
- tile_ready  in  1  datapath accepts tile
- tile_row  out  ROWB_W  row-block index
- tile_col  out  COLB_W  kernel-block index
- tile_last  out  1  final tile of the layer
- tile_done  in  1  one-cycle completion pulse, one per accepted tile
- busy  out  1  state != IDLE
- layer_done  out  1  one-cycle pulse at layer end
- err  out  1  sticky error: timeout or spurious tile_done; cleared on next cfg accept

Behaviour:
- Reset (rst high at posedge):
  - state=IDLE; all counters 0; latched descriptor 0.
  - Outputs prep_start, tile_valid, tile_last, layer_done, err, busy are 0.
  - cfg_ready=1.
  - Applies from any state, including mid-layer; in-flight tiles are forgotten.
- States: IDLE, PREP, ISSUE, DRAIN, DONE.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid: latch descriptor, clear err, go to PREP. prep_start is 1 from the next cycle.
- PREP:
  - prep_start=1; prep_* outputs held stable.
  - On the first cycle prep_enable=1, capture prep_row_blocks and prep_col_blocks.
  - If either captured count is 0, go to DONE with no tiles issued. Otherwise clear row/col indices and go to ISSUE.
  - A wait counter increments each PREP cycle. If it reaches PREP_TIMEOUT with no prep_enable: err=1, go to DONE.
- ISSUE:
  - tile_valid=1 while outstanding < MAX_OUT.
  - tile_row/tile_col/tile_last are stable while tile_valid && !tile_ready.
  - On handshake, advance row; on row wrap (row==row_blocks-1), set row=0 and advance col.
  - tile_last=1 when row==row_blocks-1 && col==col_blocks-1.
  - After the last handshake, go to DRAIN.
  - prep_start stays 1 through ISSUE and DRAIN.
- Outstanding counter (4 bits):
  - +1 on a tile handshake, -1 on tile_done; both in the same cycle leaves it unchanged.
  - tile_done while outstanding==0: ignored, err=1.
  - tile_valid is never asserted with outstanding==MAX_OUT, so the limit is never exceeded.
- DRAIN:
  - When outstanding==0 (including a tile_done that brings it to 0 this cycle), go to DONE on the next edge.
- DONE:
  - Lasts exactly one cycle: layer_done=1, prep_start=0 (clears the preparation stage), then IDLE.
  - cfg_ready=0 in DONE; a new cfg is accepted no earlier than the cycle after layer_done.
- Tile count is row_blocks*col_blocks; no tile is duplicated or skipped.
- Indices are combinational from counter registers; all other outputs are registered.

Test Plan:
- Reset mid-ISSUE with 3 tiles outstanding -> next cycle: IDLE, tile_valid=0, prep_start=0, cfg_ready=1, outstanding=0.
- cfg(T=6,K=3,C=2,S=1,N=16); prep_enable after 5 cycles with row_blocks=2, col_blocks=2; tile_ready=1 always; tile_done 3 cycles after each accept -> tiles issued in order (0,0),(1,0),(0,1),(1,1); tile_last only on (1,1); single layer_done pulse; prep_start falls in the same cycle.
- MAX_OUT=4, row_blocks=8, col_blocks=1, tile_done withheld -> exactly 4 handshakes then tile_valid=0; one tile_done -> exactly one further tile issued.
- tile_ready low for 5 cycles on tile (2,0) -> tile_row=2, tile_col=0 stable and tile_valid held high throughout.
- prep_enable never asserted, PREP_TIMEOUT=64 -> at 64 PREP cycles: err=1, layer_done pulse, no tile_valid; err clears on the next cfg accept.
- prep_col_blocks=0 -> no tiles issued, layer_done within 2 cycles of prep_enable. Spurious tile_done in IDLE -> err=1, state unchanged.
